// File: rtl/perf_pkg.sv
// Shared register map and helpers for the performance counter bank.
// Imported by the bank top and its channel sub-module.
package perf_pkg;

  localparam logic [5:0] REG_INHIBIT = 6'h00;
  localparam logic [5:0] REG_OVF     = 6'h01;
  localparam logic [5:0] REG_IRQ_EN  = 6'h02;
  localparam logic [5:0] CNT_BASE    = 6'h08;
  localparam int         CNT_STRIDE  = 4;

  localparam logic [1:0] CNT_LO  = 2'd0;
  localparam logic [1:0] CNT_HI  = 2'd1;
  localparam logic [1:0] CNT_SEL = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// Peripheral bus port of the counter bank.
// Single-cycle access strobe, read data one cycle later.
interface perf_counter_bank_if;

  logic        bus_en;
  logic        bus_we;
  logic [5:0]  bus_adr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_en,
    output bus_we,
    output bus_adr,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_en,
    input  bus_we,
    input  bus_adr,
    input  bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/perf_counter.sv
// One counter channel: increment, LO/HI load, wrap detect.
// A bus write in the same cycle beats the increment and hides the wrap.
module perf_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  assign wrap = inc && !wr_lo && !wr_hi && (&cnt);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (wr_lo) begin
      cnt[31:0] <= wdata;
    end else if (wr_hi) begin
      cnt[WIDTH-1:32] <= wdata[WIDTH-33:0];
    end else if (inc) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with shared HI snapshot and overflow IRQ.
// LO reads latch the upper half so a following HI read is torn-free.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int N_CNT = 4,
  parameter int WIDTH = 64,
  parameter int N_EV  = 8,
  parameter int SEL_W = 3
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [N_EV-1:0]     ev,
  perf_counter_bank_if.slave  bus,
  output logic                irq_ovf
);

  localparam int HW = WIDTH - 32;

  logic [N_CNT-1:0] inhibit;
  logic [N_CNT-1:0] ovf;
  logic [N_CNT-1:0] irq_en;
  logic [N_CNT-1:0] ovf_clr;
  logic [N_CNT-1:0] ev_hit;
  logic [N_CNT-1:0] inc;
  logic [N_CNT-1:0] wr_lo;
  logic [N_CNT-1:0] wr_hi;
  logic [N_CNT-1:0] wr_sel;
  logic [N_CNT-1:0] wrap;

  logic [SEL_W-1:0] sel [N_CNT];
  logic [WIDTH-1:0] cnt [N_CNT];

  logic [HW-1:0]    snap;
  logic [31:0]      snap_x;
  logic [31:0]      rdata_nxt;
  logic [WIDTH-1:0] cur;
  logic [SEL_W-1:0] cur_sel;
  logic [5:0]       rel;
  logic [3:0]       cidx;
  logic [1:0]       off;
  logic             wr;
  logic             rd;
  logic             cnt_hit;

  assign wr   = bus.bus_en && bus.bus_we;
  assign rd   = bus.bus_en && !bus.bus_we;
  assign rel  = bus.bus_adr - CNT_BASE;
  assign cidx = rel[5:2];
  assign off  = rel[1:0];

  assign cnt_hit = (bus.bus_adr >= CNT_BASE)
                && (32'(cidx) < N_CNT);

  assign ovf_clr = (wr && bus.bus_adr == REG_OVF)
                 ? bus.bus_wdata[N_CNT-1:0] : '0;

  // Out-of-range SEL values match no event and never count
  always_comb begin
    ev_hit = '0;
    inc    = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    wr_sel = '0;
    for (int i = 0; i < N_CNT; i++) begin
      for (int j = 0; j < N_EV; j++)
        if (sel[i] == SEL_W'(j)) ev_hit[i] = ev[j];
      inc[i]    = ev_hit[i] && !inhibit[i];
      wr_lo[i]  = wr && cnt_hit && cidx == 4'(i) && off == CNT_LO;
      wr_hi[i]  = wr && cnt_hit && cidx == 4'(i) && off == CNT_HI;
      wr_sel[i] = wr && cnt_hit && cidx == 4'(i) && off == CNT_SEL;
    end
  end

  always_comb begin
    cur     = '0;
    cur_sel = '0;
    for (int i = 0; i < N_CNT; i++)
      if (cidx == 4'(i)) begin
        cur     = cnt[i];
        cur_sel = sel[i];
      end
  end

  always_comb begin
    snap_x         = '0;
    snap_x[HW-1:0] = snap;
  end

  always_comb begin
    rdata_nxt = '0;
    unique case (1'b1)
      bus.bus_adr == REG_INHIBIT:  rdata_nxt[N_CNT-1:0] = inhibit;
      bus.bus_adr == REG_OVF:      rdata_nxt[N_CNT-1:0] = ovf;
      bus.bus_adr == REG_IRQ_EN:   rdata_nxt[N_CNT-1:0] = irq_en;
      cnt_hit && off == CNT_LO:    rdata_nxt = cur[31:0];
      cnt_hit && off == CNT_HI:    rdata_nxt = snap_x;
      cnt_hit && off == CNT_SEL:   rdata_nxt[SEL_W-1:0] = cur_sel;
      default:                     rdata_nxt = '0;
    endcase
  end

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    perf_counter #(
      .WIDTH (WIDTH)
    ) u_cnt (
      .clk     (clk),
      .n_reset (n_reset),
      .inc     (inc[g]),
      .wr_lo   (wr_lo[g]),
      .wr_hi   (wr_hi[g]),
      .wdata   (bus.bus_wdata),
      .cnt     (cnt[g]),
      .wrap    (wrap[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      inhibit       <= '0;
      ovf           <= '0;
      irq_en        <= '0;
      snap          <= '0;
      bus.bus_rdata <= '0;
      irq_ovf       <= 1'b0;
      for (int i = 0; i < N_CNT; i++)
        sel[i] <= (i < N_EV) ? SEL_W'(i) : '0;
    end else begin
      irq_ovf <= |(ovf & irq_en);
      // A fresh wrap outranks a W1C clear of the same bit
      ovf     <= (ovf & ~ovf_clr) | wrap;
      if (wr && bus.bus_adr == REG_INHIBIT)
        inhibit <= bus.bus_wdata[N_CNT-1:0];
      if (wr && bus.bus_adr == REG_IRQ_EN)
        irq_en <= bus.bus_wdata[N_CNT-1:0];
      for (int i = 0; i < N_CNT; i++)
        if (wr_sel[i]) sel[i] <= bus.bus_wdata[SEL_W-1:0];
      if (rd) begin
        bus.bus_rdata <= rdata_nxt;
        if (cnt_hit && off == CNT_LO)
          snap <= cur[WIDTH-1:32];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank.
// Reads queue expected data; a monitor checks it a cycle later.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] ev = '0;
  logic       irq_ovf;
  logic       rd_vld = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  perf_counter_bank_if bus();

  perf_counter_bank dut (
    .clk     (clk),
    .n_reset (n_reset),
    .ev      (ev),
    .bus     (bus.slave),
    .irq_ovf (irq_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] lo(input int i);
    return 6'(8 + 4 * i);
  endfunction

  function automatic logic [5:0] hi(input int i);
    return 6'(9 + 4 * i);
  endfunction

  function automatic logic [5:0] sl(input int i);
    return 6'(10 + 4 * i);
  endfunction

  always @(posedge clk)
    rd_vld <= bus.bus_en && !bus.bus_we && n_reset;

  always @(negedge clk) begin
    if (rd_vld) begin
      logic [31:0] e;
      string n;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got=%h", bus.bus_rdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.bus_rdata !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", n, bus.bus_rdata, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    bus.bus_en = 1'b1;
    bus.bus_we = 1'b1;
    bus.bus_adr = a;
    bus.bus_wdata = d;
    @(negedge clk);
    bus.bus_en = 1'b0;
    bus.bus_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e,
                    input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    bus.bus_en = 1'b1;
    bus.bus_we = 1'b0;
    bus.bus_adr = a;
    @(negedge clk);
    bus.bus_en = 1'b0;
  endtask

  task automatic pulse(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      ev[b] = 1'b1;
      @(negedge clk);
      ev[b] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.bus_en = 1'b0;
    bus.bus_we = 1'b0;
    bus.bus_adr = '0;
    bus.bus_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.bus_rdata, 32'h0);
    chk("rst_irq", {31'b0, irq_ovf}, 32'h0);
    n_reset = 1'b1;
    @(negedge clk);

    rd(6'h00, 32'h0, "rst_inhibit");
    rd(6'h01, 32'h0, "rst_ovf");
    rd(6'h02, 32'h0, "rst_irq_en");
    rd(sl(0), 32'h0, "rst_sel0");
    rd(sl(3), 32'h3, "rst_sel3");
    rd(lo(2), 32'h0, "rst_lo2");
    rd(6'h03, 32'h0, "unmapped_03");

    // cycle event counts for exactly 10 edges
    wr(sl(0), 32'h0);
    ev[0] = 1'b1;
    repeat (10) @(negedge clk);
    ev[0] = 1'b0;
    rd(lo(0), 32'd10, "t1_lo0");
    rd(hi(0), 32'd0, "t1_hi0");

    wr(sl(1), 32'h1);
    pulse(1, 3);
    rd(lo(1), 32'd3, "t2_lo1");
    wr(6'h00, 32'h2);
    pulse(1, 5);
    rd(lo(1), 32'd3, "t2_lo1_inhib");
    rd(6'h00, 32'h2, "t2_inhibit");

    // torn-free read across a wrap of the low half
    wr(6'h00, 32'hE);
    wr(hi(0), 32'h1);
    wr(lo(0), 32'hFFFF_FFFF);
    ev[0] = 1'b1;
    rd(lo(0), 32'hFFFF_FFFF, "t3_lo0");
    ev[0] = 1'b0;
    rd(hi(0), 32'h1, "t3_hi_snap");
    rd(lo(0), 32'h0, "t3_lo0_after");
    rd(hi(0), 32'h2, "t3_hi_after");

    wr(hi(0), 32'hFFFF_FFFF);
    wr(lo(0), 32'hFFFF_FFFE);
    wr(6'h02, 32'h1);
    ev[0] = 1'b1;
    repeat (2) @(negedge clk);
    ev[0] = 1'b0;
    chk("t4_irq_lag", {31'b0, irq_ovf}, 32'h0);
    @(negedge clk);
    chk("t4_irq_set", {31'b0, irq_ovf}, 32'h1);
    rd(6'h01, 32'h1, "t4_ovf");
    rd(lo(0), 32'h0, "t4_lo0");
    rd(hi(0), 32'h0, "t4_hi0");
    wr(6'h01, 32'h1);
    chk("t4_irq_hold", {31'b0, irq_ovf}, 32'h1);
    @(negedge clk);
    chk("t4_irq_clr", {31'b0, irq_ovf}, 32'h0);
    rd(6'h01, 32'h0, "t4_ovf_clr");

    // W1C collides with a fresh wrap
    wr(hi(0), 32'hFFFF_FFFF);
    wr(lo(0), 32'hFFFF_FFFF);
    ev[0] = 1'b1;
    wr(6'h01, 32'h1);
    ev[0] = 1'b0;
    rd(6'h01, 32'h1, "t5_ovf_kept");
    rd(lo(0), 32'h0, "t5_lo0");
    wr(6'h01, 32'h1);
    rd(6'h01, 32'h0, "t5_ovf_clr");

    wr(6'h00, 32'h0);
    ev[0] = 1'b1;
    wr(lo(0), 32'h1234_5678);
    ev[0] = 1'b0;
    rd(lo(0), 32'h1234_5678, "t6_lo_wins");
    rd(hi(0), 32'h0, "t6_hi0");
    ev[0] = 1'b1;
    wr(hi(0), 32'h0000_00AB);
    ev[0] = 1'b0;
    rd(lo(0), 32'h1234_5678, "t6_lo_keep");
    rd(hi(0), 32'hAB, "t6_hi_wins");

    wr(lo(4), 32'hDEAD_BEEF);
    rd(lo(4), 32'h0, "unmapped_cnt4");
    rd(6'h0B, 32'h0, "cnt0_plus3");

    // reset lands on an in-flight read
    wr(6'h00, 32'h5);
    wr(6'h02, 32'hF);
    wr(sl(1), 32'h7);
    rd(sl(1), 32'h7, "t6_sel1");
    bus.bus_en = 1'b1;
    bus.bus_we = 1'b0;
    bus.bus_adr = lo(0);
    n_reset = 1'b0;
    @(negedge clk);
    bus.bus_en = 1'b0;
    chk("t6_rst_rdata", bus.bus_rdata, 32'h0);
    chk("t6_rst_irq", {31'b0, irq_ovf}, 32'h0);
    n_reset = 1'b1;
    rd(hi(0), 32'h0, "t6_rst_snap");
    rd(6'h00, 32'h0, "t6_rst_inhibit");
    rd(6'h02, 32'h0, "t6_rst_irq_en");
    rd(sl(1), 32'h1, "t6_rst_sel1");
    rd(lo(0), 32'h0, "t6_rst_lo0");
    rd(hi(1), 32'h0, "t6_rst_hi1");

    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
